// File: rtl/fetch_unit.sv
// Instruction fetch unit: requests one instruction word at pc, holds it for
// decode until retired, then steps pc to the sequential, branch or jump target.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] CNT_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  pc_next_c,
    input  logic [31:0] imm_ext,
    input  logic [25:0] j_addr,
    input  logic        retire,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] retired_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        take_fetch;
    logic        take_retire;
    logic [31:0] pc_target;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        take_fetch  = 1'b0;
        take_retire = 1'b0;
        case (state)
            IDLE: begin
                state_nxt = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    take_fetch = 1'b1;
                    state_nxt  = HOLD;
                end
            end
            HOLD: begin
                instr_valid = 1'b1;
                if (retire) begin
                    take_retire = 1'b1;
                    state_nxt   = FETCH;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc;

    // Jump outranks branch whenever bit 1 of the select is set.
    always_comb begin
        pc_target = pc_plus4;
        if (pc_next_c[1]) begin
            pc_target = {pc_plus4[31:28], j_addr, 2'b00};
        end else if (pc_next_c[0]) begin
            pc_target = pc_plus4 + (imm_ext << 2);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            instr       <= 32'h0000_0000;
            retired_cnt <= CNT_RESET;
        end else begin
            if (take_fetch) begin
                instr <= imem_rdata;
            end
            if (take_retire) begin
                pc          <= pc_target;
                retired_cnt <= retired_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a driver plays memory and retire stage,
// a monitor pops expected fetches/holds and compares them as the DUT shows them.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PRESET   = 32'hFFFF_FFFE;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  pc_next_c = 2'b00;
    logic [31:0] imm_ext = 32'h0;
    logic [25:0] j_addr = 26'h0;
    logic        retire = 1'b0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;

    logic        imem_req, instr_valid;
    logic [31:0] imem_addr, instr, pc, pc_plus4, retired_cnt;
    logic        w_imem_req, w_instr_valid;
    logic [31:0] w_imem_addr, w_instr, w_pc, w_pc_plus4, w_retired_cnt;

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .pc_next_c(pc_next_c), .imm_ext(imm_ext),
        .j_addr(j_addr), .retire(retire), .imem_req(imem_req),
        .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .instr_valid(instr_valid), .pc(pc),
        .pc_plus4(pc_plus4), .retired_cnt(retired_cnt)
    );

    // Twin with its retire counter preset just below the wrap point.
    fetch_unit #(.RESET_PC(RESET_PC), .CNT_RESET(PRESET)) dut_wrap (
        .clk(clk), .rst(rst), .pc_next_c(pc_next_c), .imm_ext(imm_ext),
        .j_addr(j_addr), .retire(retire), .imem_req(w_imem_req),
        .imem_addr(w_imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(w_instr), .instr_valid(w_instr_valid), .pc(w_pc),
        .pc_plus4(w_pc_plus4), .retired_cnt(w_retired_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] cnt;
    } hold_t;

    logic [31:0] addr_q[$];
    hold_t       hold_q[$];
    int          len_q[$];

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] pc_model;
    logic [31:0] cnt_model;

    function automatic void checkOutput(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] nextPc(logic [31:0] cur, logic [1:0] c,
                                           logic [31:0] imm, logic [25:0] j);
        logic [31:0] seq;
        seq = cur + 32'd4;
        if (c[1]) return (seq & 32'hF000_0000) | ({6'b0, j} * 32'd4);
        if (c[0]) return seq + imm * 32'd4;
        return seq;
    endfunction

    task automatic scrambleCtl();
        pc_next_c = 2'($urandom);
        imm_ext   = $urandom;
        j_addr    = 26'($urandom);
    endtask

    task automatic checkReset();
        checkOutput("rst_req", {31'b0, imem_req}, 32'd0);
        checkOutput("rst_valid", {31'b0, instr_valid}, 32'd0);
        checkOutput("rst_pc", pc, RESET_PC);
        checkOutput("rst_pc_plus4", pc_plus4, RESET_PC + 32'd4);
        checkOutput("rst_instr", instr, 32'd0);
        checkOutput("rst_cnt", retired_cnt, 32'd0);
        checkOutput("rst_wrap_cnt", w_retired_cnt, PRESET);
    endtask

    // One full transaction: wait for the request, ack after lat cycles,
    // hold a few cycles with stray acks, then retire (optionally under reset).
    task automatic applyStimulus(input int lat, input logic [31:0] data,
                                 input logic [1:0] c, input logic [31:0] imm,
                                 input logic [25:0] j, input bit rst_at_retire);
        int    n;
        hold_t h;
        n = 0;
        while (!imem_req) begin
            if (n == 8) begin
                $display("[TB] FAIL req_timeout: got 0 expected 1");
                n_fail++;
                $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
                $fatal(1, "[TB] no fetch request");
            end
            retire = 1'($urandom);
            scrambleCtl();
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < lat; i++) begin
            imem_ack = 1'b0;
            retire   = 1'($urandom);
            scrambleCtl();
            @(negedge clk);
        end
        imem_ack   = 1'b1;
        imem_rdata = data;
        retire     = 1'($urandom);
        h.pc = pc_model; h.instr = data; h.cnt = cnt_model;
        hold_q.push_back(h);
        len_q.push_back(lat + 1);
        @(negedge clk);
        retire = 1'b0;
        imem_ack = 1'b0;
        for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
            imem_ack   = 1'($urandom);
            imem_rdata = $urandom;
            scrambleCtl();
            @(negedge clk);
        end
        imem_ack   = 1'($urandom);
        imem_rdata = $urandom;
        retire     = 1'b1;
        pc_next_c  = c;
        imm_ext    = imm;
        j_addr     = j;
        if (rst_at_retire) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            retire = 1'b0;
            imem_ack = 1'b0;
            pc_model  = RESET_PC;
            cnt_model = 32'd0;
            checkReset();
            addr_q.push_back(RESET_PC);
        end else begin
            pc_model  = nextPc(pc_model, c, imm, j);
            cnt_model = cnt_model + 32'd1;
            addr_q.push_back(pc_model);
            @(negedge clk);
            retire = 1'b0;
            imem_ack = 1'b0;
            scrambleCtl();
        end
    endtask

    // Reset while a request is outstanding, with its ack arriving in IDLE.
    task automatic resetDuringFetch();
        while (!imem_req) @(negedge clk);
        rst = 1'b1;
        imem_ack = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        pc_model  = RESET_PC;
        cnt_model = 32'd0;
        checkReset();
        addr_q.push_back(RESET_PC);
        @(negedge clk);
        imem_ack = 1'b0;
        checkOutput("fresh_req", {31'b0, imem_req}, 32'd1);
        checkOutput("late_ack_instr", instr, 32'd0);
    endtask

    // Monitor: consumes expectations when the DUT presents a request or a held instruction.
    initial begin
        logic [31:0] cur_addr;
        hold_t       cur;
        logic        prev_req, prev_valid, abandon;
        int          req_len;
        prev_req = 1'b0; prev_valid = 1'b0; abandon = 1'b1; req_len = 0;
        cur_addr = 32'h0; cur.pc = 32'h0; cur.instr = 32'h0; cur.cnt = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) abandon = 1'b1;
            if (imem_req && !prev_req) begin
                abandon = 1'b0;
                req_len = 0;
                if (addr_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("[TB] FAIL addr_q_empty: got req at %h expected none", imem_addr);
                end else begin
                    cur_addr = addr_q.pop_front();
                end
            end
            if (imem_req) begin
                req_len++;
                checkOutput("fetch_addr", imem_addr, cur_addr);
                checkOutput("wrap_fetch_addr", w_imem_addr, cur_addr);
                checkOutput("wrap_req", {31'b0, w_imem_req}, 32'd1);
                checkOutput("req_excl_valid", {31'b0, instr_valid}, 32'd0);
            end
            if (!imem_req && prev_req && !abandon) begin
                if (len_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("[TB] FAIL len_q_empty: got req drop expected none");
                end else begin
                    checkOutput("req_len", 32'(req_len), 32'(len_q.pop_front()));
                end
            end
            if (instr_valid && !prev_valid) begin
                if (hold_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("[TB] FAIL hold_q_empty: got valid expected none");
                end else begin
                    cur = hold_q.pop_front();
                    checkOutput("hold_cnt", retired_cnt, cur.cnt);
                    checkOutput("wrap_cnt", w_retired_cnt, cur.cnt + PRESET);
                    checkOutput("hold_pc_plus4", pc_plus4, cur.pc + 32'd4);
                    checkOutput("wrap_pc_plus4", w_pc_plus4, cur.pc + 32'd4);
                end
            end
            if (instr_valid) begin
                checkOutput("hold_instr", instr, cur.instr);
                checkOutput("hold_pc", pc, cur.pc);
                checkOutput("wrap_instr", w_instr, cur.instr);
                checkOutput("wrap_pc", w_pc, cur.pc);
                checkOutput("wrap_valid", {31'b0, w_instr_valid}, 32'd1);
            end
            prev_req   = imem_req;
            prev_valid = instr_valid;
        end
    end

    // Driver: reset, directed PC scenarios, random traffic, then reset corner cases.
    initial begin
        pc_model  = RESET_PC;
        cnt_model = 32'd0;
        repeat (3) @(negedge clk);
        checkReset();
        rst = 1'b0;
        addr_q.push_back(RESET_PC);

        applyStimulus(2, 32'h2008_0005, 2'b10, 32'h0, 26'h40, 1'b0);
        applyStimulus(0, $urandom, 2'b00, 32'h0, 26'h0, 1'b0);
        applyStimulus(1, $urandom, 2'b10, 32'h0, 26'h40, 1'b0);
        applyStimulus(3, $urandom, 2'b01, 32'hFFFF_FFFE, 26'h0, 1'b0);
        applyStimulus(0, $urandom, 2'b10, 32'h0, 26'h40, 1'b0);
        applyStimulus(2, $urandom, 2'b01, 32'h0000_0003, 26'h0, 1'b0);
        applyStimulus(1, $urandom, 2'b10, 32'h0, 26'h40, 1'b0);
        applyStimulus(0, $urandom, 2'b01, 32'h0BFF_FFC3, 26'h0, 1'b0);
        applyStimulus(1, $urandom, 2'b11, 32'h0000_0007, 26'h40, 1'b0);

        for (int k = 0; k < 40; k++) begin
            applyStimulus(int'($urandom_range(0, 3)), $urandom, 2'($urandom),
                          32'($signed($urandom_range(0, 64)) - 32), 26'($urandom), 1'b0);
        end

        resetDuringFetch();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(int'($urandom_range(0, 3)), $urandom, 2'($urandom),
                          $urandom, 26'($urandom), 1'b0);
        end
        applyStimulus(1, $urandom, 2'b00, 32'h0, 26'h0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(int'($urandom_range(0, 3)), $urandom, 2'($urandom),
                          $urandom, 26'($urandom), 1'b0);
        end
        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
